// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - PC sequencer with prefetch FIFO between instruction memory and decode
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          DEPTH     = 2,
    parameter int          MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0]      PC_LIMIT = 32'(MEM_WORDS * 4);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               fault_q, fault_d;
    logic [31:0]        pc_buf_q [DEPTH];
    logic [31:0]        pc_buf_d [DEPTH];
    logic [31:0]        instr_buf_q [DEPTH];
    logic [31:0]        instr_buf_d [DEPTH];

    logic pc_legal;
    logic pop;
    logic push;
    logic redirect_take;

    // Handshake qualifiers; a redirect blocks the push because the PC is being replaced
    always_comb begin
        pc_legal      = (pc_q[1:0] == 2'b00) && (pc_q < PC_LIMIT);
        pop           = (count_q != '0) && out_ready;
        redirect_take = redirect_valid && (state_q != S_HALT);
        push          = (state_q == S_RUN) && !redirect_valid && pc_legal
                        && ((count_q < DEPTH_C) || pop);
    end

    // Next-state logic for the control FSM, PC and prefetch FIFO
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fault_d     = fault_q;
        pc_buf_d    = pc_buf_q;
        instr_buf_d = instr_buf_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!redirect_valid && !pc_legal) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else if (!fetch_en) begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redirect_take) begin
            // Flush discards everything, including an entry popped this cycle
            pc_d     = redirect_pc;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                pc_buf_d[wr_ptr_q]    = pc_q;
                instr_buf_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d              = wr_ptr_q + PTR_ONE;
                pc_d                  = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // State registers; reset clears control state, buffer contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fault_q  <= fault_d;
        end
    end

    // FIFO storage needs no reset; reads are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        pc_buf_q    <= pc_buf_d;
        instr_buf_q <= instr_buf_d;
    end

    // Head of FIFO drives decode; zeros when empty so downstream never sees X
    always_comb begin
        imem_addr = pc_q;
        out_valid = (count_q != '0);
        fault     = fault_q;
        out_pc    = '0;
        out_instr = '0;
        if (count_q != '0) begin
            out_pc    = pc_buf_q[rd_ptr_q];
            out_instr = instr_buf_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - directed vector bench for instr_fetch_ctrl
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    int tests  = 0;
    int failed = 0;

    instr_fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(2), .MEM_WORDS(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[17:2]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    typedef struct {
        logic        r;
        logic        fe;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic        ef;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic fe, input logic rv,
                                input logic [31:0] rpc, input logic rdy,
                                input logic ev, input logic [31:0] epc,
                                input logic [31:0] eaddr, input logic ef);
        vec_t t;
        t.r = r; t.fe = fe; t.rv = rv; t.rpc = rpc; t.rdy = rdy;
        t.ev = ev; t.epc = epc; t.eaddr = eaddr; t.ef = ef;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic fe, input logic rv,
                         input logic [31:0] rpc, input logic rdy);
        rst = r; fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input int idx, input logic ev,
                            input logic [31:0] epc, input logic [31:0] eaddr, input logic ef);
        chk({tag, "_valid"}, idx, {31'b0, out_valid}, {31'b0, ev});
        chk({tag, "_pc"},    idx, out_pc,    ev ? epc : 32'h0);
        chk({tag, "_instr"}, idx, out_instr, ev ? mem_word(epc) : 32'h0);
        chk({tag, "_addr"},  idx, imem_addr, eaddr);
        chk({tag, "_fault"}, idx, {31'b0, fault}, {31'b0, ef});
    endtask

    initial begin
        int cyc;
        logic [31:0] exp_pc;

        rst = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

        // r fe rv rpc rdy | valid pc addr fault
        vecs.push_back(mk(0,0,0,32'h00,0, 0,32'h00,32'h00,0));  // reset
        vecs.push_back(mk(1,1,0,32'h00,1, 0,32'h00,32'h00,0));  // IDLE->RUN
        vecs.push_back(mk(1,1,0,32'h00,1, 1,32'h00,32'h04,0));  // first push
        vecs.push_back(mk(1,1,0,32'h00,1, 1,32'h04,32'h08,0));
        vecs.push_back(mk(1,1,0,32'h00,1, 1,32'h08,32'h0C,0));
        vecs.push_back(mk(0,1,0,32'h00,1, 0,32'h00,32'h00,0));  // reset
        vecs.push_back(mk(1,1,0,32'h00,0, 0,32'h00,32'h00,0));
        vecs.push_back(mk(1,1,0,32'h00,0, 1,32'h00,32'h04,0));
        vecs.push_back(mk(1,1,0,32'h00,0, 1,32'h00,32'h08,0));  // full
        vecs.push_back(mk(1,1,0,32'h00,0, 1,32'h00,32'h08,0));  // held
        vecs.push_back(mk(1,1,0,32'h00,0, 1,32'h00,32'h08,0));
        vecs.push_back(mk(1,1,0,32'h00,1, 1,32'h04,32'h0C,0));  // push+pop while full
        vecs.push_back(mk(1,1,0,32'h00,1, 1,32'h08,32'h10,0));
        vecs.push_back(mk(1,1,0,32'h00,1, 1,32'h0C,32'h14,0));
        vecs.push_back(mk(1,1,0,32'h00,0, 1,32'h0C,32'h14,0));
        vecs.push_back(mk(1,1,1,32'h20,1, 0,32'h00,32'h20,0));  // redirect+pop, full
        vecs.push_back(mk(1,1,0,32'h00,1, 1,32'h20,32'h24,0));
        vecs.push_back(mk(1,1,0,32'h00,1, 1,32'h24,32'h28,0));
        vecs.push_back(mk(1,1,1,32'h22,0, 0,32'h00,32'h22,0));  // misaligned redirect
        vecs.push_back(mk(1,1,0,32'h00,1, 0,32'h00,32'h22,1));  // HALT
        vecs.push_back(mk(1,1,1,32'h00,1, 0,32'h00,32'h22,1));  // redirect ignored
        vecs.push_back(mk(1,1,0,32'h00,1, 0,32'h00,32'h22,1));
        vecs.push_back(mk(0,0,0,32'h00,0, 0,32'h00,32'h00,0));  // reset out of HALT
        vecs.push_back(mk(1,0,1,32'hF8,0, 0,32'h00,32'hF8,0));  // redirect in IDLE
        vecs.push_back(mk(1,1,0,32'h00,0, 0,32'h00,32'hF8,0));
        vecs.push_back(mk(1,1,0,32'h00,0, 1,32'hF8,32'hFC,0));
        vecs.push_back(mk(1,1,0,32'h00,0, 1,32'hF8,32'h100,0));
        vecs.push_back(mk(1,1,0,32'h00,0, 1,32'hF8,32'h100,1)); // run-off -> HALT
        vecs.push_back(mk(1,1,0,32'h00,1, 1,32'hFC,32'h100,1)); // drain in HALT
        vecs.push_back(mk(1,1,0,32'h00,1, 0,32'h00,32'h100,1));
        vecs.push_back(mk(1,1,0,32'h00,1, 0,32'h00,32'h100,1));
        vecs.push_back(mk(0,0,0,32'h00,0, 0,32'h00,32'h00,0));
        vecs.push_back(mk(1,1,0,32'h00,0, 0,32'h00,32'h00,0));
        vecs.push_back(mk(1,1,0,32'h00,0, 1,32'h00,32'h04,0));
        vecs.push_back(mk(1,1,0,32'h00,0, 1,32'h00,32'h08,0));  // full
        vecs.push_back(mk(0,1,0,32'h00,0, 0,32'h00,32'h00,0));  // reset mid-stream
        vecs.push_back(mk(1,1,0,32'h00,0, 0,32'h00,32'h00,0));
        vecs.push_back(mk(1,1,0,32'h00,0, 1,32'h00,32'h04,0));  // restart from RESET_PC
        vecs.push_back(mk(1,0,0,32'h00,0, 1,32'h00,32'h08,0));  // last RUN cycle still pushes
        vecs.push_back(mk(1,0,0,32'h00,1, 1,32'h04,32'h08,0));  // paused, draining
        vecs.push_back(mk(1,0,0,32'h00,1, 0,32'h00,32'h08,0));  // PC retained

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].fe, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            chk_outs("vec", i, vecs[i].ev, vecs[i].epc, vecs[i].eaddr, vecs[i].ef);
        end

        // Stream latency and steady one-per-cycle throughput
        drive(0, 0, 0, 32'h0, 1);
        rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!out_valid && cyc < 10);
        chk("stream_latency", 0, 32'(cyc), 32'd2);
        exp_pc = 32'h0;
        for (int k = 0; k < 16; k++) begin
            chk("stream_valid", k, {31'b0, out_valid}, 32'd1);
            chk("stream_pc", k, out_pc, exp_pc);
            chk("stream_instr", k, out_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            @(posedge clk);
            #1;
        end

        // Redirect from full FIFO without a pop: old entries never reach decode
        drive(0, 0, 0, 32'h0, 0);
        drive(1, 1, 0, 32'h0, 0);
        drive(1, 1, 0, 32'h0, 0);
        drive(1, 1, 0, 32'h0, 0);
        chk("full_addr", 0, imem_addr, 32'h8);
        drive(1, 1, 1, 32'h20, 0);
        chk("flush_valid", 0, {31'b0, out_valid}, 32'd0);
        exp_pc = 32'h20;
        rst = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("redir_pc", k, out_pc, exp_pc);
            exp_pc = exp_pc + 32'd4;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
